// File: rtl/ram_pkg.sv
// ram_pkg: shared types and RAM window helper for the even/odd RAM port controller
package ram_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;
  typedef enum logic {LANE_EVEN, LANE_ODD} lane_t;
  function automatic logic [15:0] ram_base(input int addrbits);
    return 16'h4000 - 16'(32'd1 << (addrbits - 1));
  endfunction
endpackage

// File: rtl/ram_access_if.sv
// ram_access_if: CPU-side request/response handshake of ram_access
interface ram_access_if;
  logic req_valid, req_ready, req_write, req_word;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_rdata;
  modport master (
    output req_valid, req_write, req_word, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_write, req_word, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ram_lane_map.sv
// ram_lane_map: steers a byte/word access onto the even and odd bank addresses
module ram_lane_map import ram_pkg::*; (
  input  logic [14:0] addr,
  input  logic        word,
  output logic [14:0] addr_even,
  output logic [14:0] addr_odd,
  output logic        en_even,
  output logic        en_odd,
  output lane_t       swap
);
  logic [14:0] addr_nx;
  always_comb begin
    addr_nx   = addr + 15'd1;
    swap      = lane_t'(addr[0]);
    en_even   = word | ~addr[0];
    en_odd    = word | addr[0];
    addr_even = addr[0] ? addr_nx : addr;
    addr_odd  = addr[0] ? addr : addr_nx;
  end
endmodule

// File: rtl/ram_access.sv
// ram_access: even/odd RAM port controller; define RAM_ACCESS_RANGE_CHECK_EN to flag out-of-window accesses
module ram_access import ram_pkg::*; #(
  parameter int ADDRBITS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  ram_access_if.slave bus,
  output logic [14:0] dread_addr_even,
  output logic [14:0] dread_addr_odd,
  input  logic [7:0]  dread_data_even,
  input  logic [7:0]  dread_data_odd,
  output logic [14:0] dwrite_addr_even,
  output logic [14:0] dwrite_addr_odd,
  output logic [7:0]  dwrite_data_even,
  output logic [7:0]  dwrite_data_odd,
  output logic        dwrite_en_even,
  output logic        dwrite_en_odd
);
  localparam logic [14:0] ROW_MASK = 15'((32'd1 << ADDRBITS) - 32'd1);
  state_t state_q, state_d;
  lane_t swap, swap_q, swap_d;
  logic word_q, word_d, err_q, err_d, rsp_err_q, rsp_err_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic [14:0] rd_even_q, rd_even_d, rd_odd_q, rd_odd_d, lane_even, lane_odd;
  logic en_even, en_odd, acc, acc_rd, acc_wr, err;

  ram_lane_map u_map (
    .addr(bus.req_addr), .word(bus.req_word), .addr_even(lane_even), .addr_odd(lane_odd),
    .en_even, .en_odd, .swap
  );

`ifdef RAM_ACCESS_RANGE_CHECK_EN
  localparam logic [15:0] BASE = ram_base(ADDRBITS);
  logic [15:0] last_byte;
  always_comb begin
    last_byte = {1'b0, bus.req_addr} + 16'(bus.req_word);
    err       = ({1'b0, bus.req_addr} < BASE) || (last_byte > 16'h3fff);
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    bus.req_ready    = reset_n && (state_q == IDLE || (state_q == RSP && bus.rsp_ready));
    acc              = bus.req_valid && bus.req_ready;
    acc_wr           = acc && bus.req_write;
    acc_rd           = acc && !bus.req_write;
    bus.rsp_valid    = state_q == RSP;
    bus.rsp_rdata    = rsp_rdata_q;
    bus.rsp_err      = rsp_err_q;
    dwrite_en_even   = acc_wr && en_even && !err;
    dwrite_en_odd    = acc_wr && en_odd && !err;
    dwrite_addr_even = acc_wr ? lane_even & ROW_MASK : '0;
    dwrite_addr_odd  = acc_wr ? lane_odd & ROW_MASK : '0;
    // the addressed byte is the high byte of a word, so it takes wdata[15:8]
    dwrite_data_even = !acc_wr ? 8'h00 :
                       (bus.req_word && swap == LANE_EVEN) ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
    dwrite_data_odd  = !acc_wr ? 8'h00 :
                       (bus.req_word && swap == LANE_ODD) ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
    rd_even_d        = (acc_rd && en_even) ? lane_even & ROW_MASK : rd_even_q;
    rd_odd_d         = (acc_rd && en_odd) ? lane_odd & ROW_MASK : rd_odd_q;
    dread_addr_even  = rd_even_d;
    dread_addr_odd   = rd_odd_d;
  end

  always_comb begin
    swap_d      = acc_rd ? swap : swap_q;
    word_d      = acc_rd ? bus.req_word : word_q;
    err_d       = acc_rd ? err : err_q;
    rsp_err_d   = state_q == RD_WAIT ? err_q : rsp_err_q;
    rsp_rdata_d = state_q != RD_WAIT ? rsp_rdata_q :
                  err_q ? (word_q ? 16'hffff : 16'h00ff) :
                  word_q ? (swap_q == LANE_ODD ? {dread_data_odd, dread_data_even}
                                               : {dread_data_even, dread_data_odd}) :
                  {8'h00, swap_q == LANE_ODD ? dread_data_odd : dread_data_even};
    state_d     = state_q == RD_WAIT ? RSP :
                  (state_q == RSP && !bus.rsp_ready) ? RSP :
                  acc_rd ? RD_WAIT : IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      swap_q      <= LANE_EVEN;
      word_q      <= 1'b0;
      err_q       <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rd_even_q   <= '0;
      rd_odd_q    <= '0;
    end else begin
      state_q     <= state_d;
      swap_q      <= swap_d;
      word_q      <= word_d;
      err_q       <= err_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rd_even_q   <= rd_even_d;
      rd_odd_q    <= rd_odd_d;
    end
  end
endmodule

// File: tb/tb_ram_access.sv
// tb_ram_access: directed vectors for ram_access against a two-bank RAM model
`timescale 1ns/1ps
module tb_ram_access;
  localparam int ADDRBITS = 10;
`ifdef RAM_ACCESS_RANGE_CHECK_EN
  localparam logic [14:0] B = 15'h3e00;
`else
  localparam logic [14:0] B = 15'h3c00;
`endif
  localparam logic [14:0] M = 15'h03ff;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [14:0] dread_addr_even, dread_addr_odd, dwrite_addr_even, dwrite_addr_odd;
  logic [7:0] dread_data_even, dread_data_odd, dwrite_data_even, dwrite_data_odd;
  logic dwrite_en_even, dwrite_en_odd;
  logic [7:0] mem_even [512];
  logic [7:0] mem_odd [512];
  int n_vec = 0, n_err = 0, rsp_cnt = 0, stb_cnt = 0;
  logic mon_en = 1'b0;

  ram_access_if bus();

  ram_access #(.ADDRBITS(ADDRBITS)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .dread_addr_even(dread_addr_even), .dread_addr_odd(dread_addr_odd),
    .dread_data_even(dread_data_even), .dread_data_odd(dread_data_odd),
    .dwrite_addr_even(dwrite_addr_even), .dwrite_addr_odd(dwrite_addr_odd),
    .dwrite_data_even(dwrite_data_even), .dwrite_data_odd(dwrite_data_odd),
    .dwrite_en_even(dwrite_en_even), .dwrite_en_odd(dwrite_en_odd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 512; i++) begin
        mem_even[i] <= 8'h00;
        mem_odd[i]  <= 8'h00;
      end
      dread_data_even <= 8'h00;
      dread_data_odd  <= 8'h00;
    end else begin
      if (dwrite_en_even) mem_even[dwrite_addr_even[9:1]] <= dwrite_data_even;
      if (dwrite_en_odd) mem_odd[dwrite_addr_odd[9:1]] <= dwrite_data_odd;
      dread_data_even <= mem_even[dread_addr_even[9:1]];
      dread_data_odd  <= mem_odd[dread_addr_odd[9:1]];
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      rsp_cnt <= rsp_cnt + int'(bus.rsp_valid);
      stb_cnt <= stb_cnt + int'(dwrite_en_even | dwrite_en_odd);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic wd, input logic [14:0] a, input logic [15:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_word  = wd;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic wr(input logic wd, input logic [14:0] a, input logic [15:0] d);
    drive(1'b1, wd, a, d);
    wait_ready("wr");
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 20);
  endtask

  task automatic rd(input string tag, input logic wd, input logic [14:0] a,
                    input logic [15:0] exp_d, input logic exp_e);
    int lat;
    bus.rsp_ready = 1'b1;
    drive(1'b0, wd, a, 16'h0000);
    wait_ready(tag);
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_data"}, 32'(bus.rsp_rdata), 32'(exp_d));
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_e));
    tick();
  endtask

  initial begin
    int lat;
    logic ok;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_word  = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("rst_err", 32'(bus.rsp_err), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_raddr", 32'({dread_addr_even, dread_addr_odd}), 32'd0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(bus.req_ready), 32'd1);
    check("idle_wen", 32'({dwrite_en_even, dwrite_en_odd}), 32'd0);
    tick();

    drive(1'b1, 1'b1, B + 15'h10, 16'hA1B2);
    wait_ready("w1");
    check("w1_en", 32'({dwrite_en_even, dwrite_en_odd}), 32'd3);
    check("w1_data", 32'({dwrite_data_even, dwrite_data_odd}), 32'hA1B2);
    check("w1_addr", 32'(dwrite_addr_even), 32'((B + 15'h10) & M));
    tick();
    bus.req_valid = 1'b0;
    rd("r1", 1'b1, B + 15'h10, 16'hA1B2, 1'b0);

    drive(1'b1, 1'b1, B + 15'h11, 16'h1234);
    wait_ready("w2");
    check("w2_en", 32'({dwrite_en_even, dwrite_en_odd}), 32'd3);
    check("w2_data", 32'({dwrite_data_even, dwrite_data_odd}), 32'h3412);
    check("w2_addr", 32'({dwrite_addr_even, dwrite_addr_odd}),
          32'({(B + 15'h12) & M, (B + 15'h11) & M}));
    tick();
    bus.req_valid = 1'b0;
    rd("r2a", 1'b0, B + 15'h11, 16'h0012, 1'b0);
    rd("r2b", 1'b0, B + 15'h12, 16'h0034, 1'b0);
    rd("r2c", 1'b1, B + 15'h11, 16'h1234, 1'b0);

    drive(1'b1, 1'b0, B + 15'h30, 16'hFFC3);
    wait_ready("wb_e");
    check("wb_e_en", 32'({dwrite_en_even, dwrite_en_odd}), 32'd2);
    check("wb_e_data", 32'(dwrite_data_even), 32'hC3);
    tick();
    bus.req_valid = 1'b0;
    rd("raw_e", 1'b0, B + 15'h30, 16'h00C3, 1'b0);
    drive(1'b1, 1'b0, B + 15'h31, 16'h005E);
    wait_ready("wb_o");
    check("wb_o_en", 32'({dwrite_en_even, dwrite_en_odd}), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    rd("raw_w", 1'b1, B + 15'h30, 16'hC35E, 1'b0);

    wr(1'b1, B + 15'h20, 16'h5A6B);
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b1, B + 15'h20, 16'h0000);
    wait_ready("bp");
    tick();
    drive(1'b0, 1'b0, B + 15'h21, 16'h0000);
    wait_rsp(lat);
    check("bp_lat", 32'(lat), 32'd2);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ok &= bus.rsp_valid && bus.rsp_rdata == 16'h5A6B && !bus.req_ready;
      if (i < 4) @(negedge clk);
    end
    check("bp_hold", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'({bus.req_ready, bus.rsp_valid}), 32'd3);
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(lat);
    check("bp2_lat", 32'(lat), 32'd2);
    check("bp2_data", 32'(bus.rsp_rdata), 32'h006B);
    tick();

`ifdef RAM_ACCESS_RANGE_CHECK_EN
    drive(1'b1, 1'b1, 15'h3fff, 16'hBEEF);
    wait_ready("oor_w");
    check("oor_w_en", 32'({dwrite_en_even, dwrite_en_odd}), 32'd0);
    tick();
    drive(1'b1, 1'b0, 15'h3000, 16'h0055);
    wait_ready("oor_b");
    check("oor_b_en", 32'({dwrite_en_even, dwrite_en_odd}), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    rd("oor_rw", 1'b1, 15'h3fff, 16'hFFFF, 1'b1);
    rd("oor_rb", 1'b0, 15'h3000, 16'h00FF, 1'b1);
    rd("inr_rb", 1'b0, B + 15'h30, 16'h00C3, 1'b0);
`else
    drive(1'b1, 1'b1, 15'h3fff, 16'hBEEF);
    wait_ready("wrap_w");
    check("wrap_en", 32'({dwrite_en_even, dwrite_en_odd}), 32'd3);
    check("wrap_data", 32'({dwrite_data_even, dwrite_data_odd}), 32'hEFBE);
    tick();
    bus.req_valid = 1'b0;
    rd("wrap_r", 1'b1, 15'h3fff, 16'hBEEF, 1'b0);
    rd("alias_r", 1'b0, 15'h0000, 16'h00EF, 1'b0);
`endif

    drive(1'b0, 1'b1, B + 15'h10, 16'h0000);
    wait_ready("rst_rd");
    tick();
    bus.req_valid = 1'b0;
    reset_n = 1'b0;
    mon_en = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    mon_en = 1'b0;
    @(negedge clk);
    check("mid_rst_rsp", 32'(rsp_cnt), 32'd0);
    check("mid_rst_stb", 32'(stb_cnt), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
